eq_gain_scheduler: RTL and testbench
====================================

Name: eq_gain_scheduler

Overview:
Control block for the 10-band equalizer amplifier gains. Collects gain change requests from a host write port and from front-panel buttons, and holds a target gain per band. It ramps the live gains toward their targets one LSB at a time, only on sample boundaries, so that band gains never jump mid-sample. Its output drives the equalizer's amplifier_gains bus directly.

Parameters:
NUMBER_OF_FILTERS, 10, number of bands (at least 2)
GAIN_BITS, 4, width of each unsigned gain
GAIN_DEFAULT, 1, gain value applied at reset and on preset_load
RAMP_DIV, 8, qualifying sample boundaries per ramp step (at least 1)
BAND_BITS, $clog2(NUMBER_OF_FILTERS), width of band index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_enable  in  1  datapath clock enable, same signal as the equalizer's
phase_min  in  1  sample-boundary flag from the equalizer counter
host_valid  in  1  host write request
host_ready  out  1  host write accept
host_band  in  BAND_BITS  target band of the host write
host_gain  in  GAIN_BITS  new target gain
btn_next  in  1  one-cycle pulse, already debounced: select next band
btn_up  in  1  one-cycle pulse: selected band target +1
btn_down  in  1  one-cycle pulse: selected band target -1
preset_load  in  1  one-cycle pulse: all targets set to GAIN_DEFAULT
sel_band  out  BAND_BITS  band currently selected by the buttons
amplifier_gains  out  NUMBER_OF_FILTERS*GAIN_BITS  live gains; band k sits at [(k+1)*GAIN_BITS-1 : k*GAIN_BITS]
busy  out  1  high while any live gain differs from its target
update_done  out  1  one-cycle pulse when a ramp completes
err_band  out  1  one-cycle pulse when a host write names a band >= NUMBER_OF_FILTERS

Behaviour:
- Reset values: every target and every live gain = GAIN_DEFAULT; sel_band = 0; busy = 0; update_done = 0; err_band = 0; ramp counter = 0; state = IDLE.
- host_ready = 1 in every cycle except the cycle where preset_load = 1. A write is accepted when host_valid and host_ready are both high; it updates target[host_band] on the next clock edge.
- Host write to a band >= NUMBER_OF_FILTERS: the write is accepted but ignored, and err_band pulses in the following cycle.
- Request priority within one cycle: preset_load, then host write, then buttons. Any lower-priority target change in the same cycle is dropped.
- btn_next is never dropped. It moves sel_band to sel_band+1, wrapping from NUMBER_OF_FILTERS-1 to 0.
- If btn_up and btn_down arrive in the same cycle, both are ignored.
- btn_up saturates the target at 2^GAIN_BITS-1; btn_down saturates it at 0.
- btn_up and btn_down act on the sel_band value from before any btn_next in the same cycle.
- Requests are handled on every clk cycle, independent of clk_enable.
- A qualifying boundary is a cycle where clk_enable = 1 and phase_min = 1.
- State machine:
  - IDLE: all live gains equal their targets. Moves to RAMP on the cycle after any target differs from its live gain. On entry to RAMP the ramp counter is cleared to 0.
  - RAMP: on each qualifying boundary the ramp counter increments. When it reaches RAMP_DIV-1, it wraps to 0 and every mismatched band moves its live gain one LSB toward its target, all bands in the same edge.
  - RAMP to IDLE: when all live gains equal their targets after a step, or immediately if a new target write re-matches every band. update_done pulses in the cycle after entering IDLE.
- A target change during RAMP retargets without clearing the ramp counter.
- busy is registered and is 1 exactly when state = RAMP.
- Latency: the first step lands on the RAMP_DIV-th qualifying boundary after RAMP is entered.
- An asynchronous reset mid-ramp restores every reset value immediately; no update_done is produced.

Decomposition:
- Shared package: state encoding (IDLE, RAMP), GAIN_MAX constant, and a saturating +1/-1 gain helper function.
- One natural sub-module: eq_gain_ramp_cell, one per band. It holds target and live gain, performs the single-LSB step, and outputs a mismatch flag. The top level keeps the arbitration, sel_band, ramp counter and FSM, and ORs the per-band mismatch flags.

Test Plan:
- Reset, then hold: amplifier_gains = 10 copies of 4'd1; busy = 0; host_ready = 1; sel_band = 0.
- Host write band 3 = 5, phase_min pulsing every 16 clks, clk_enable = 1: band 3 steps 1, 2, 3, 4, 5 on the 8th, 16th, 24th and 32nd boundaries; busy falls after the last step; update_done pulses once; other bands stay at 1.
- btn_next ×9 then ×1: sel_band reaches 9, then wraps to 0. btn_up ×20 on band 0: target saturates at 15. btn_down ×20: target saturates at 0.
- Same cycle preset_load + host_valid (band 2 = 9) + btn_up: host_ready = 0, all targets = 1, band 2 stays 1.
- Host write band 12: accepted; err_band pulses once; amplifier_gains unchanged; busy stays 0.
- clk_enable = 0 with phase_min toggling during a ramp: no steps occur. Retarget mid-ramp from 5 back to 1: band reverses direction. Assert rst mid-ramp: all gains return to 1 immediately and no update_done pulses.

Source files
------------

// File: rtl/eq_gain_scheduler_pkg.sv
// Shared types and helpers for the equalizer gain scheduler.
// Holds the FSM encoding, the default-width gain limit and the saturating step.
package eq_gain_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam int GAIN_BITS_DEF = 4;
  localparam int GAIN_MAX      = (1 << GAIN_BITS_DEF) - 1;

  // One LSB up or down, clamped to [0, gmax].
  function automatic int sat_step(input int g, input int gmax, input logic up);
    if (up) begin
      return (g >= gmax) ? gmax : g + 1;
    end
    return (g <= 0) ? 0 : g - 1;
  endfunction

endpackage

// File: rtl/eq_gain_ramp_cell.sv
// One equalizer band: stores target and live gain, moves live one LSB
// toward target when step_en is high, and flags any mismatch.
module eq_gain_ramp_cell #(
  parameter int GAIN_BITS    = 4,
  parameter int GAIN_DEFAULT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgt_we,
  input  logic [GAIN_BITS-1:0] tgt_wdata,
  input  logic                 step_en,
  output logic [GAIN_BITS-1:0] target,
  output logic [GAIN_BITS-1:0] live,
  output logic                 mismatch
);

  localparam logic [GAIN_BITS-1:0] GAIN_RST = GAIN_BITS'(GAIN_DEFAULT);

  logic [GAIN_BITS-1:0] target_q, target_d;
  logic [GAIN_BITS-1:0] live_q, live_d;

  always_comb begin
    target_d = tgt_we ? tgt_wdata : target_q;
    live_d   = live_q;
    // Direction is taken from the pre-edge target, so a same-edge retarget
    // only influences the following step.
    if (step_en && (live_q != target_q)) begin
      live_d = (target_q > live_q) ? live_q + 1'b1 : live_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= GAIN_RST;
      live_q   <= GAIN_RST;
    end else begin
      target_q <= target_d;
      live_q   <= live_d;
    end
  end

  assign target   = target_q;
  assign live     = live_q;
  assign mismatch = (target_q != live_q);

endmodule

// File: rtl/eq_gain_scheduler.sv
// Equalizer gain scheduler: arbitrates host/button/preset target changes and
// ramps live band gains one LSB per RAMP_DIV qualifying sample boundaries.
module eq_gain_scheduler
  import eq_gain_scheduler_pkg::*;
#(
  parameter int NUMBER_OF_FILTERS = 10,
  parameter int GAIN_BITS         = GAIN_BITS_DEF,
  parameter int GAIN_DEFAULT      = 1,
  parameter int RAMP_DIV          = 8,
  parameter int BAND_BITS         = $clog2(NUMBER_OF_FILTERS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_enable,
  input  logic                                   phase_min,
  input  logic                                   host_valid,
  output logic                                   host_ready,
  input  logic [BAND_BITS-1:0]                   host_band,
  input  logic [GAIN_BITS-1:0]                   host_gain,
  input  logic                                   btn_next,
  input  logic                                   btn_up,
  input  logic                                   btn_down,
  input  logic                                   preset_load,
  output logic [BAND_BITS-1:0]                   sel_band,
  output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
  output logic                                   busy,
  output logic                                   update_done,
  output logic                                   err_band
);

  localparam int                    CNT_BITS   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int                    GAIN_LIMIT = (1 << GAIN_BITS) - 1;
  localparam logic [GAIN_BITS-1:0]  GAIN_RST   = GAIN_BITS'(GAIN_DEFAULT);
  localparam logic [CNT_BITS-1:0]   CNT_LAST   = CNT_BITS'(RAMP_DIV - 1);
  localparam logic [BAND_BITS-1:0]  BAND_LAST  = BAND_BITS'(NUMBER_OF_FILTERS - 1);

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [BAND_BITS-1:0] sel_band_q, sel_band_d;
  logic                 update_done_q, update_done_d;
  logic                 err_band_q, err_band_d;

  logic host_acc, host_bad, btn_adj, boundary, step_en, any_mismatch;
  logic [NUMBER_OF_FILTERS-1:0] mismatch;
  logic [GAIN_BITS-1:0]         target [NUMBER_OF_FILTERS];
  logic [GAIN_BITS-1:0]         live   [NUMBER_OF_FILTERS];

  assign host_ready   = ~preset_load;
  assign host_acc     = host_valid & ~preset_load;
  assign host_bad     = int'(host_band) >= NUMBER_OF_FILTERS;
  assign btn_adj      = btn_up ^ btn_down;
  assign boundary     = clk_enable & phase_min;
  assign any_mismatch = |mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_FILTERS; gi++) begin : g_band
      logic                 we;
      logic [GAIN_BITS-1:0] wdata;

      // Preset beats host, host beats buttons; an accepted host write to a bad
      // band still consumes the cycle's button adjustment.
      always_comb begin
        we    = 1'b0;
        wdata = target[gi];
        if (preset_load) begin
          we    = 1'b1;
          wdata = GAIN_RST;
        end else if (host_acc) begin
          if (!host_bad && (host_band == BAND_BITS'(gi))) begin
            we    = 1'b1;
            wdata = host_gain;
          end
        end else if (btn_adj && (sel_band_q == BAND_BITS'(gi))) begin
          we    = 1'b1;
          wdata = GAIN_BITS'(sat_step(int'(target[gi]), GAIN_LIMIT, btn_up));
        end
      end

      eq_gain_ramp_cell #(
        .GAIN_BITS   (GAIN_BITS),
        .GAIN_DEFAULT(GAIN_DEFAULT)
      ) u_cell (
        .clk      (clk),
        .rst      (rst),
        .tgt_we   (we),
        .tgt_wdata(wdata),
        .step_en  (step_en),
        .target   (target[gi]),
        .live     (live[gi]),
        .mismatch (mismatch[gi])
      );

      assign amplifier_gains[gi*GAIN_BITS +: GAIN_BITS] = live[gi];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_en       = 1'b0;
    update_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_mismatch) state_d = RAMP;
      end
      RAMP: begin
        if (!any_mismatch) begin
          state_d       = IDLE;
          update_done_d = 1'b1;
        end else if (boundary) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            step_en = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_band_d = sel_band_q;
    if (btn_next) begin
      sel_band_d = (sel_band_q == BAND_LAST) ? '0 : sel_band_q + 1'b1;
    end
    err_band_d = host_acc & host_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_band_q    <= '0;
      update_done_q <= 1'b0;
      err_band_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_band_q    <= sel_band_d;
      update_done_q <= update_done_d;
      err_band_q    <= err_band_d;
    end
  end

  assign busy        = (state_q == RAMP);
  assign sel_band    = sel_band_q;
  assign update_done = update_done_q;
  assign err_band    = err_band_q;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler: a request table for arbitration and
// band selection, plus hand-written ramp, saturation and reset sequences.
module tb_eq_gain_scheduler;

  localparam int NF = 10;
  localparam int GB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_enable = 1'b1;
  logic          phase_min = 1'b0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [3:0]    host_band = '0;
  logic [3:0]    host_gain = '0;
  logic          btn_next = 1'b0;
  logic          btn_up = 1'b0;
  logic          btn_down = 1'b0;
  logic          preset_load = 1'b0;
  logic [3:0]    sel_band;
  logic [NF*GB-1:0] amplifier_gains;
  logic          busy;
  logic          update_done;
  logic          err_band;

  eq_gain_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .clk_enable     (clk_enable),
    .phase_min      (phase_min),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_band      (host_band),
    .host_gain      (host_gain),
    .btn_next       (btn_next),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .preset_load    (preset_load),
    .sel_band       (sel_band),
    .amplifier_gains(amplifier_gains),
    .busy           (busy),
    .update_done    (update_done),
    .err_band       (err_band)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ud_count = 0;
  int err_count = 0;

  always @(posedge clk) begin
    #1;
    if (update_done === 1'b1) ud_count++;
    if (err_band === 1'b1) err_count++;
  end

  typedef struct {
    logic       pl;
    logic       hv;
    logic [3:0] hb;
    logic [3:0] hg;
    logic       nx;
    logic       up;
    logic       dn;
    logic       exp_ready;
    logic [3:0] exp_sel;
    logic       exp_err;
  } vec_t;

  vec_t vecs[14];
  logic [NF*GB-1:0] exp_gains;
  logic [NF*GB-1:0] all_default;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic pl, input logic hv, input logic [3:0] hb, input logic [3:0] hg,
                       input logic nx, input logic up, input logic dn);
    preset_load = pl;
    host_valid  = hv;
    host_band   = hb;
    host_gain   = hg;
    btn_next    = nx;
    btn_up      = up;
    btn_down    = dn;
  endtask

  task automatic pulse(input logic pl, input logic hv, input logic [3:0] hb, input logic [3:0] hg,
                       input logic nx, input logic up, input logic dn);
    drive(pl, hv, hb, hg, nx, up, dn);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic host_write(input logic [3:0] band, input logic [3:0] gain);
    pulse(1'b0, 1'b1, band, gain, 1'b0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic boundary(input int gap);
    phase_min  = 1'b0;
    clk_enable = 1'b1;
    repeat (gap - 1) @(negedge clk);
    phase_min = 1'b1;
    @(negedge clk);
    phase_min = 1'b0;
  endtask

  task automatic ramp_wait(input string name);
    int n;
    n = 0;
    idle(2);
    while (busy && n < 3000) begin
      boundary(2);
      n++;
    end
    idle(2);
    check({name, "_done"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] band_gain(input int k);
    return amplifier_gains[k*GB +: GB];
  endfunction

  initial begin
    int ud_base;
    int err_base;

    for (int k = 0; k < NF; k++) all_default[k*GB +: GB] = 4'd1;

    //               pl    hv    hb     hg    nx    up    dn   rdy  sel   err
    for (int i = 0; i < 9; i++) vecs[i] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i + 1), 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd12, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'd2,  4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd15, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_gains", 64'(amplifier_gains), 64'(all_default));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(host_ready), 64'd1);
    check("rst_sel", 64'(sel_band), 64'd0);
    check("rst_update_done", 64'(update_done), 64'd0);
    check("rst_err_band", 64'(err_band), 64'd0);

    // Request table: selection wrap, readiness, bad-band errors, priority drops
    err_base = err_count;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pl, vecs[i].hv, vecs[i].hb, vecs[i].hg, vecs[i].nx, vecs[i].up, vecs[i].dn);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(host_ready), 64'(vecs[i].exp_ready));
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_sel", i), 64'(sel_band), 64'(vecs[i].exp_sel));
      check($sformatf("vec%0d_err", i), 64'(err_band), 64'(vecs[i].exp_err));
    end
    idle(3);
    check("table_err_pulses", 64'(err_count - err_base), 64'd2);
    check("table_busy", 64'(busy), 64'd0);
    check("table_gains", 64'(amplifier_gains), 64'(all_default));

    // Basic ramp: band 3 to 5, boundary every 16 clocks
    do_reset();
    ud_base = ud_count;
    host_write(4'd3, 4'd5);
    check("rampB_busy_start", 64'(busy), 64'd1);
    for (int i = 1; i <= 32; i++) begin
      boundary(16);
      check($sformatf("rampB_b%0d_band3", i), 64'(band_gain(3)), 64'(1 + i / 8));
      if (i == 31) check("rampB_busy_b31", 64'(busy), 64'd1);
    end
    idle(3);
    check("rampB_busy_end", 64'(busy), 64'd0);
    check("rampB_update_done", 64'(ud_count - ud_base), 64'd1);
    exp_gains = all_default;
    exp_gains[3*GB +: GB] = 4'd5;
    check("rampB_gains", 64'(amplifier_gains), 64'(exp_gains));

    // Button saturation on band 0
    do_reset();
    repeat (20) pulse(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    ramp_wait("sat_up");
    check("sat_up_band0", 64'(band_gain(0)), 64'd14);
    repeat (20) pulse(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    ramp_wait("sat_dn");
    check("sat_dn_band0", 64'(band_gain(0)), 64'd0);

    // Priority and same-cycle button interactions
    do_reset();
    drive(1'b1, 1'b1, 4'd2, 4'd9, 1'b0, 1'b1, 1'b0);
    #1;
    check("prio_ready_low", 64'(host_ready), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("prio_preset_busy", 64'(busy), 64'd0);
    check("prio_preset_gains", 64'(amplifier_gains), 64'(all_default));
    pulse(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b1, 4'd5, 4'd3, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    check("prio_sel", 64'(sel_band), 64'd1);
    ramp_wait("prio");
    exp_gains = all_default;
    exp_gains[0*GB +: GB] = 4'd2;
    exp_gains[5*GB +: GB] = 4'd3;
    check("prio_gains", 64'(amplifier_gains), 64'(exp_gains));

    // clk_enable gating, mid-ramp reversal, asynchronous reset
    do_reset();
    host_write(4'd3, 4'd5);
    clk_enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      phase_min = ~phase_min;
      @(negedge clk);
    end
    phase_min  = 1'b0;
    clk_enable = 1'b1;
    check("gate_band3", 64'(band_gain(3)), 64'd1);
    check("gate_busy", 64'(busy), 64'd1);
    repeat (8) boundary(2);
    check("gate_step1", 64'(band_gain(3)), 64'd2);
    repeat (8) boundary(2);
    check("gate_step2", 64'(band_gain(3)), 64'd3);
    host_write(4'd3, 4'd1);
    repeat (8) boundary(2);
    check("reverse_band3", 64'(band_gain(3)), 64'd2);
    check("reverse_busy", 64'(busy), 64'd1);
    ud_base = ud_count;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gains", 64'(amplifier_gains), 64'(all_default));
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("async_rst_no_done", 64'(ud_count - ud_base), 64'd0);
    check("async_rst_busy_after", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
